wsa_adc_interface: RTL and testbench

WSA_ADC_INTERFACE -- requirements
Module: wsa_adc_interface

---
 rtl/wsa_adc_if.sv | 9 +
 rtl/wsa_adc_interface.sv | 130 +++++++++++++
 tb/tb_wsa_adc_interface.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wsa_adc_if.sv
// Settings-bus bundle for wsa_adc_interface: one-cycle write strobe with address and data.
interface wsa_adc_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, output serial_data, output serial_strobe);
  modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/wsa_adc_interface.sv
// Dual-ADC front end: DC-offset removal, saturation and channel mux into the DDC inputs.
// Optional RSSI accumulator and over-range counter are built when WSA_ADC_RSSI_EN is defined.
module wsa_adc_interface (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  wsa_adc_if.slave    sbus,
  input  logic [11:0] rx_a_a,
  input  logic [11:0] rx_b_a,
  output logic [15:0] ddc0_in_i,
  output logic [15:0] ddc0_in_q,
  output logic [3:0]  rx_numchan,
  output logic [31:0] rssi_0
);

  logic [15:0] off_a_q, off_a_d, off_b_q, off_b_d;
  logic [7:0]  rx_mux_q, rx_mux_d;
  logic [1:0]  dco_en_q, dco_en_d;
  logic [15:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [15:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [15:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic        unused_data;

  assign unused_data = ^sbus.serial_data[31:16];

  // Signed subtract with clamp to the 16-bit two's-complement range.
  function automatic logic [15:0] sat_sub(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] diff;
    diff = {x[15], x} - {y[15], y};
    if (diff[16] != diff[15]) return diff[16] ? 16'h8000 : 16'h7FFF;
    return diff[15:0];
  endfunction

  function automatic logic [15:0] sel_chan(input logic [1:0] sel, input logic [15:0] a,
                                           input logic [15:0] b);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    off_a_d  = off_a_q;
    off_b_d  = off_b_q;
    rx_mux_d = rx_mux_q;
    dco_en_d = dco_en_q;
    if (sbus.serial_strobe) begin
      case (sbus.serial_addr)
        7'd10:   off_a_d  = sbus.serial_data[15:0];
        7'd11:   off_b_d  = sbus.serial_data[15:0];
        7'd38:   rx_mux_d = sbus.serial_data[7:0];
        7'd39:   dco_en_d = sbus.serial_data[1:0];
        default: ;
      endcase
    end
    s1_a_d  = enable ? {rx_a_a, 4'b0000} : 16'h0000;
    s1_b_d  = enable ? {rx_b_a, 4'b0000} : 16'h0000;
    s2_a_d  = dco_en_q[0] ? sat_sub(s1_a_q, off_a_q) : s1_a_q;
    s2_b_d  = dco_en_q[1] ? sat_sub(s1_b_q, off_b_q) : s1_b_q;
    out_i_d = sel_chan(rx_mux_q[5:4], s2_a_q, s2_b_q);
    out_q_d = sel_chan(rx_mux_q[7:6], s2_a_q, s2_b_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      off_a_q  <= '0;
      off_b_q  <= '0;
      rx_mux_q <= '0;
      dco_en_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      out_i_q  <= '0;
      out_q_q  <= '0;
    end else begin
      off_a_q  <= off_a_d;
      off_b_q  <= off_b_d;
      rx_mux_q <= rx_mux_d;
      dco_en_q <= dco_en_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s2_a_q   <= s2_a_d;
      s2_b_q   <= s2_b_d;
      out_i_q  <= out_i_d;
      out_q_q  <= out_q_d;
    end
  end

  assign ddc0_in_i  = out_i_q;
  assign ddc0_in_q  = out_q_q;
  assign rx_numchan = rx_mux_q[3:0];

`ifdef WSA_ADC_RSSI_EN
  logic [25:0] acc_q, acc_d;
  logic [15:0] ovr_q, ovr_d;
  logic [11:0] top_a, mag_a;
  logic        ovr_hit, ovr_clr;

  // Leaky integrator settles at 1024*|A|, so acc[25:10] tracks the mean magnitude.
  always_comb begin
    top_a   = s1_a_q[15:4];
    mag_a   = top_a;
    if (top_a == 12'h800)  mag_a = 12'h7FF;
    else if (top_a[11])    mag_a = -top_a;
    acc_d   = acc_q + {14'b0, mag_a} - {10'b0, acc_q[25:10]};
    ovr_hit = (top_a == 12'h7FF) || (top_a == 12'h800);
    ovr_clr = sbus.serial_strobe && (sbus.serial_addr == 7'd40);
    ovr_d   = ovr_q;
    if (ovr_clr)                          ovr_d = 16'h0000;
    else if (ovr_hit && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovr_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovr_q <= ovr_d;
    end
  end

  assign rssi_0 = {ovr_q, acc_q[25:10]};
`else
  assign rssi_0 = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_wsa_adc_interface.sv
// Directed bench for wsa_adc_interface; expectations follow the WSA_ADC_RSSI_EN build setting.
module tb_wsa_adc_interface;

`ifdef WSA_ADC_RSSI_EN
  localparam bit RSSI = 1'b1;
`else
  localparam bit RSSI = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] rx_a_a, rx_b_a;
  logic [15:0] ddc0_in_i, ddc0_in_q;
  logic [3:0]  rx_numchan;
  logic [31:0] rssi_0;
  int          n_tests = 0;
  int          n_fail  = 0;

  wsa_adc_if sbus ();

  wsa_adc_interface dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sbus       (sbus),
    .rx_a_a     (rx_a_a),
    .rx_b_a     (rx_b_a),
    .ddc0_in_i  (ddc0_in_i),
    .ddc0_in_q  (ddc0_in_q),
    .rx_numchan (rx_numchan),
    .rssi_0     (rssi_0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wreg(input logic [6:0] addr, input logic [31:0] data);
    sbus.serial_addr   = addr;
    sbus.serial_data   = data;
    sbus.serial_strobe = 1'b1;
    tick(1);
    sbus.serial_strobe = 1'b0;
  endtask

  initial begin
    logic [15:0] rs;
    reset = 1'b1; enable = 1'b0; rx_a_a = '0; rx_b_a = '0;
    sbus.serial_addr = '0; sbus.serial_data = '0; sbus.serial_strobe = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_i", ddc0_in_i, 0);
    check("rst_q", ddc0_in_q, 0);
    check("rst_numchan", rx_numchan, 0);
    check("rst_rssi", rssi_0, 0);
    reset = 1'b0;

    wreg(38, 'h00);
    enable = 1'b1; rx_a_a = 12'h123;
    tick(2);
    check("lat_2cyc_i", ddc0_in_i, 0);
    tick(1);
    check("lat_3cyc_i", ddc0_in_i, 16'h1230);
    check("lat_3cyc_q", ddc0_in_q, 16'h1230);
    check("mux0_numchan", rx_numchan, 0);

    wreg(38, 'h92); rx_a_a = 12'h001; rx_b_a = 12'h7FF;
    tick(4);
    check("mux92_i", ddc0_in_i, 16'h7FF0);
    check("mux92_q", ddc0_in_q, 16'h0000);
    check("mux92_numchan", rx_numchan, 2);

    wreg(38, 'h40); tick(4);
    check("mux40_i", ddc0_in_i, 16'h0010);
    check("mux40_q", ddc0_in_q, 16'h7FF0);
    wreg(38, 'h30); tick(4);
    check("mux30_i", ddc0_in_i, 16'h0000);
    check("mux30_q", ddc0_in_q, 16'h0010);

    wreg(37, 'hFF); wreg(12, 'hFFFF); tick(4);
    check("ignore_numchan", rx_numchan, 0);
    check("ignore_q", ddc0_in_q, 16'h0010);

    wreg(38, 'h40); wreg(10, 'h0010); wreg(39, 1); tick(4);
    check("offa_zero_i", ddc0_in_i, 16'h0000);
    check("offb_off_q", ddc0_in_q, 16'h7FF0);
    wreg(11, 'hFFF0); wreg(39, 3); tick(4);
    check("offb_satpos_q", ddc0_in_q, 16'h7FFF);
    rx_a_a = 12'h800; wreg(10, 'h7FFF); tick(4);
    check("offa_satneg_i", ddc0_in_i, 16'h8000);
    wreg(39, 0); tick(4);
    check("dco_off_i", ddc0_in_i, 16'h8000);
    check("dco_off_q", ddc0_in_q, 16'h7FF0);
    rx_a_a = 12'h001; wreg(10, 'h0020); wreg(39, 1); tick(4);
    check("offa_neg_i", ddc0_in_i, 16'hFFF0);

    wreg(39, 0); enable = 1'b0; rx_a_a = 12'h555;
    tick(3);
    check("disable_i", ddc0_in_i, 0);
    check("disable_q", ddc0_in_q, 0);
    enable = 1'b1; wreg(38, 'h02); tick(4);
    check("pre_rst_i", ddc0_in_i, 16'h5550);
    check("pre_rst_numchan", rx_numchan, 2);

    #2 reset = 1'b1;
    #1;
    check("async_rst_i", ddc0_in_i, 0);
    check("async_rst_q", ddc0_in_q, 0);
    check("async_rst_numchan", rx_numchan, 0);
    check("async_rst_rssi", rssi_0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);
    check("post_rst_2cyc_i", ddc0_in_i, 0);
    tick(1);
    check("post_rst_3cyc_i", ddc0_in_i, 16'h5550);

    wreg(40, 0);
    rx_a_a = 12'h7FF; tick(5);
    rx_a_a = 12'h000; tick(3);
    check("ovr_count5", rssi_0[31:16], RSSI ? 32'd5 : 32'd0);
    wreg(40, 0);
    check("ovr_clear", rssi_0[31:16], 0);
    rx_a_a = 12'h800; tick(1);
    wreg(40, 0);
    check("ovr_clear_wins", rssi_0[31:16], 0);
    tick(1);
    check("ovr_after_clear", rssi_0[31:16], RSSI ? 32'd1 : 32'd0);

    rx_a_a = 12'h3E8;
    tick(10000);
    rs = rssi_0[15:0];
    if (RSSI) check("rssi_settle", {31'b0, (rs >= 16'd990 && rs <= 16'd1000)}, 1);
    else      check("rssi_zero", rssi_0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
